sw_input_port: RTL and testbench

- Input-side counterpart of the seven-segment output path. It lets the operator hand a value to the K2 core from the board switches and centre button.
- Synchronises SW and BTNC, then debounces the button with an FSM.
- On each clean button press, captures the switch word into a data register and raises a valid flag.
- The core consumes the word with a one-cycle read strobe. Sits between the board pins and the processor input port in the FPGA top.

---
 rtl/input_port_pkg.sv | 17 +
 rtl/bit_sync.sv | 33 +++
 rtl/sw_input_port.sv | 127 ++++++++++++
 tb/tb_sw_input_port.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_port_pkg.sv
// Shared types and defaults for the switch/button input port.
// Holds the debounce FSM state type and the default tuning constants.
package input_port_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } btn_state_t;

   // 10 ms of stable level at 100 MHz.
   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int SYNC_STAGES_DEF     = 2;
   localparam int BITS_DEF            = 8;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for asynchronous board inputs.
// Ports: clk, rst (async, active high), d (raw), q (synchronised).
module bit_sync #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Fewer than two flops gives no metastability margin.
   localparam int D = (DEPTH < 2) ? 2 : DEPTH;

   logic [WIDTH-1:0] stg [D];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < D; i++) begin
            stg[i] <= '0;
         end
      end else begin
         stg[0] <= d;
         for (int i = 1; i < D; i++) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   assign q = stg[D-1];

endmodule

// File: rtl/sw_input_port.sv
// Switch-word input port: sync, debounce button, capture on press.
// Ports: clk, rst, sw, btn, rd_en -> data_out, valid, overrun, btn_level.
module sw_input_port
   import input_port_pkg::*;
#(
   parameter int bits            = BITS_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [bits-1:0] sw,
   input  logic            btn,
   input  logic            rd_en,
   output logic [bits-1:0] data_out,
   output logic            valid,
   output logic            overrun,
   output logic            btn_level
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [bits-1:0] sw_s;
   logic            btn_s;

   btn_state_t      state;
   btn_state_t      state_d;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_d;
   logic            capture;

   bit_sync #(
      .WIDTH (bits),
      .DEPTH (SYNC_STAGES)
   ) u_sw_sync (
      .clk (clk),
      .rst (rst),
      .d   (sw),
      .q   (sw_s)
   );

   bit_sync #(
      .WIDTH (1),
      .DEPTH (SYNC_STAGES)
   ) u_btn_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn),
      .q   (btn_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // cnt is cleared on every wait-state entry, so it never wraps.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      capture = 1'b0;
      unique case (state)
         IDLE: begin
            if (btn_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_d = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_d = PRESSED;
               capture = 1'b1;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_d = PRESSED;
            end else if (cnt == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The level is high from the capture edge until release settles.
   assign btn_level = (state == PRESSED) ||
                      (state == RELEASE_WAIT);

   // A read in the capture cycle consumes the old word, so the
   // new one does not count as an overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
      end else if (capture) begin
         data_out <= sw_s;
         valid    <= 1'b1;
         overrun  <= rd_en ? 1'b0 : (overrun | valid);
      end else if (rd_en && valid) begin
         valid    <= 1'b0;
         overrun  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sw_input_port.sv
// Self-checking bench for sw_input_port (DEBOUNCE_CYCLES=4, SYNC=2).
// Table of presses plus hand sequences; expectations via a queue.
module tb_sw_input_port;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sw;
   logic       btn;
   logic       rd_en;
   logic [7:0] data_out;
   logic       valid;
   logic       overrun;
   logic       btn_level;

   sw_input_port #(
      .bits            (8),
      .DEBOUNCE_CYCLES (4),
      .SYNC_STAGES     (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .btn       (btn),
      .rd_en     (rd_en),
      .data_out  (data_out),
      .valid     (valid),
      .overrun   (overrun),
      .btn_level (btn_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] d;
      logic       v;
      logic       o;
      logic       l;
      string      nm;
   } exp_t;

   typedef struct {
      logic [7:0] sw;
      logic [7:0] sw_late;
      int         hold;
      logic       rd_cap;
      logic       rd_after;
      logic [7:0] e_d;
      logic       e_v;
      logic       e_o;
      logic       e_l;
   } vec_t;

   exp_t       sbq[$];
   vec_t       vt[8];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   logic [7:0] p_d;
   logic       p_v;
   logic       p_o;

   function automatic void chk(string nm,
                               logic [10:0] act,
                               logic [10:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got d=%h v=%b o=%b l=%b want d=%h v=%b o=%b l=%b",
                  nm, act[10:3], act[2], act[1], act[0],
                  exp[10:3], exp[2], exp[1], exp[0]);
      end
   endfunction

   function automatic void push(int c, logic [7:0] d, logic v,
                                logic o, logic l, string nm);
      exp_t e;
      e.cyc = c;
      e.d   = d;
      e.v   = v;
      e.o   = o;
      e.l   = l;
      e.nm  = nm;
      sbq.push_back(e);
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         exp_t e;
         e = sbq.pop_front();
         if (e.cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL %s: check for cycle %0d missed at %0d",
                     e.nm, e.cyc, cyc);
         end else begin
            chk(e.nm, {data_out, valid, overrun, btn_level},
                {e.d, e.v, e.o, e.l});
         end
      end
   endtask

   task automatic do_read(string nm);
      rd_en = 1'b1;
      p_v   = 1'b0;
      p_o   = 1'b0;
      push(cyc + 1, p_d, 1'b0, 1'b0, 1'b0, nm);
      tick();
      rd_en = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int n;
      n   = cyc;
      sw  = v.sw;
      btn = 1'b1;
      push(n + 6, p_d, p_v, p_o, 1'b0, $sformatf("v%0d_pre", idx));
      push(n + 7, v.e_d, v.e_v, v.e_o, v.e_l,
           $sformatf("v%0d_cap", idx));
      push(n + v.hold + 8, v.e_d, v.e_v, v.e_o, 1'b0,
           $sformatf("v%0d_rel", idx));
      for (int i = 1; i <= v.hold + 10; i++) begin
         tick();
         if (i == 3) sw = v.sw_late;
         if (i == 8) sw = ~v.sw_late;
         if (i == v.hold) btn = 1'b0;
         rd_en = v.rd_cap && (i == 6);
      end
      p_d = v.e_d;
      p_v = v.e_v;
      p_o = v.e_o;
      if (v.rd_after) do_read($sformatf("v%0d_rd", idx));
   endtask

   initial begin
      int m;
      rst   = 1'b1;
      sw    = 8'h00;
      btn   = 1'b0;
      rd_en = 1'b0;
      p_d   = 8'h00;
      p_v   = 1'b0;
      p_o   = 1'b0;

      vt[0] = '{8'h77, 8'h77,  3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vt[1] = '{8'hA5, 8'hA5, 20, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
      vt[2] = '{8'h3C, 8'h3C,  8, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1};
      vt[3] = '{8'h11, 8'h11,  8, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
      vt[4] = '{8'h22, 8'h22,  8, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1};
      vt[5] = '{8'h5A, 8'h5A,  8, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1};
      vt[6] = '{8'h96, 8'h96,  8, 1'b1, 1'b0, 8'h96, 1'b1, 1'b0, 1'b1};
      vt[7] = '{8'hC3, 8'h4B, 10, 1'b0, 1'b1, 8'h4B, 1'b1, 1'b1, 1'b1};

      tick();
      chk("reset_state", {data_out, valid, overrun, btn_level}, 11'h0);
      tick();
      rst = 1'b0;
      tick();

      for (int k = 0; k < 8; k++) begin
         run_vec(vt[k], k);
      end

      // Read with nothing pending is ignored.
      do_read("rd_idle");

      // Release bounce: two low cycles while held, no recapture.
      m   = cyc;
      sw  = 8'hE7;
      btn = 1'b1;
      push(m + 6, p_d, p_v, p_o, 1'b0, "bnc_pre");
      push(m + 7, 8'hE7, 1'b1, 1'b0, 1'b1, "bnc_cap");
      for (int i = 11; i <= 20; i++) begin
         push(m + i, 8'hE7, 1'b1, 1'b0, 1'b1, $sformatf("bnc_%0d", i));
      end
      push(m + 30, 8'hE7, 1'b1, 1'b0, 1'b0, "bnc_rel");
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (i == 8) sw = 8'h18;
         if (i == 10) btn = 1'b0;
         if (i == 12) btn = 1'b1;
         if (i == 20) btn = 1'b0;
      end
      p_d = 8'hE7;
      p_v = 1'b1;
      p_o = 1'b0;
      do_read("bnc_rd");

      // Async reset mid-press, then button held through release.
      m   = cyc;
      sw  = 8'h66;
      btn = 1'b1;
      push(m + 7, 8'h66, 1'b1, 1'b0, 1'b1, "pre_rst_cap");
      for (int i = 1; i <= 9; i++) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async", {data_out, valid, overrun, btn_level}, 11'h0);
      tick();
      tick();
      rst = 1'b0;
      sw  = 8'h99;
      m   = cyc;
      push(m + 6, 8'h00, 1'b0, 1'b0, 1'b0, "held_pre");
      push(m + 7, 8'h99, 1'b1, 1'b0, 1'b1, "held_cap");
      push(m + 16, 8'h99, 1'b1, 1'b0, 1'b0, "held_rel");
      for (int i = 1; i <= 18; i++) begin
         tick();
         if (i == 8) btn = 1'b0;
      end

      // Reset with button low: nothing captured afterwards.
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async2", {data_out, valid, overrun, btn_level}, 11'h0);
      tick();
      rst = 1'b0;
      m   = cyc;
      sw  = 8'hFF;
      push(m + 12, 8'h00, 1'b0, 1'b0, 1'b0, "rst_idle");
      for (int i = 1; i <= 14; i++) tick();

      while (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         total++;
         bad++;
         $display("FAIL %s: check for cycle %0d never reached",
                  e.nm, e.cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
